mmcm_lock_ctrl: RTL and testbench
=================================

Name: mmcm_lock_ctrl

Overview:
- Controller on the far side of the clock wizard's control/status interface: it drives the wizard reset and consumes its locked output.
- Pulses the MMCM reset, waits for lock with a timeout and bounded retries, and qualifies lock for a stable interval.
- Only then releases a system reset for the camera/capture/display logic, which runs on the wizard output clocks.
- Runs on the free-running 50 MHz board clock, the same clock that feeds the wizard.

Parameters:
- RST_PULSE_CYC, 16: cycles mmcm_rst is held high per reset pulse (≥1).
- LOCK_TIMEOUT_CYC, 65535: cycles to wait for lock after the pulse before retrying (~1.3 ms at 50 MHz).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock cycles required before release (≥1).
- MAX_RETRY, 3: timeouts tolerated before declaring failure (1..15).

Ports:
- clk_in1  input  1  free-running 50 MHz board clock.
- reset  input  1  asynchronous active-low reset.
- locked  input  1  MMCM locked status; asynchronous to clk_in1.
- soft_rst  input  1  synchronous request to restart the full sequence; level, sampled each edge.
- mmcm_rst  output  1  active-high reset to the clock wizard.
- sys_rst_n  output  1  active-low reset for downstream logic.
- clk_ok  output  1  high while clocks are qualified (state RUN).
- fail  output  1  high in state FAIL.
- retry_cnt  output  4  number of lock timeouts since the last RUN entry or soft_rst.

Behaviour:
- Reset (reset=0, asynchronous): state=PLL_RST, cnt=0, sync FFs=0, mmcm_rst=1, sys_rst_n=0, clk_ok=0, fail=0, retry_cnt=0.
- Deassertion is sampled on the next clk_in1 edge.
- locked passes through a 2-FF synchronizer; locked_s is the second stage. This gives 2 edges of latency.
- All outputs are registered and take the value of the next state on the same edge. They are pure functions of the state except retry_cnt.
- Single counter cnt, width clog2(max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)+1). cnt clears on every state change.
- PLL_RST:
  - mmcm_rst=1, sys_rst_n=0.
  - Stays exactly RST_PULSE_CYC edges, then moves to WAIT_LOCK.
- WAIT_LOCK:
  - mmcm_rst=0, sys_rst_n=0.
  - locked_s=1 → STABLE.
  - Otherwise, after LOCK_TIMEOUT_CYC edges, retry_cnt increments. If the new retry_cnt > MAX_RETRY → FAIL; else → PLL_RST.
- STABLE:
  - mmcm_rst=0, sys_rst_n=0.
  - locked_s=0 → WAIT_LOCK with cnt cleared; timeout restarts and retry_cnt is unchanged.
  - After LOCK_STABLE_CYC consecutive edges → RUN.
- RUN:
  - sys_rst_n=1, clk_ok=1, retry_cnt cleared on entry.
  - locked_s=0 → PLL_RST on the same edge, so sys_rst_n and clk_ok drop.
- FAIL:
  - fail=1, mmcm_rst=0, sys_rst_n=0, clk_ok=0.
  - Exited only by soft_rst or reset; locked is ignored.
- soft_rst=1 has priority over all transitions in every state: next state PLL_RST, cnt=0, retry_cnt=0, fail=0.
- Held soft_rst keeps the block in PLL_RST; the pulse count starts from its release.
- Timing, with locked rising just before edge E0:
  - locked_s=1 after E1.
  - STABLE is entered at E2.
  - RUN is entered, and sys_rst_n/clk_ok rise, at edge E2+LOCK_STABLE_CYC.
- Lock loss in RUN: sys_rst_n falls at E2 after locked falls (3 edges including E0).
- retry_cnt saturates at 15 and never wraps.

Test Plan (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=8, MAX_RETRY=2):
- Normal bring-up:
  - Stimulus: release reset; model raises locked 20 cycles after mmcm_rst falls.
  - Response: mmcm_rst high exactly 4 edges after reset release; sys_rst_n and clk_ok rise at the 11th edge counting the first edge sampling locked=1; retry_cnt=0; fail=0.
- Lock timeout and failure:
  - Stimulus: locked held 0.
  - Response: mmcm_rst 4-cycle pulses with a 104-cycle period; retry_cnt goes 1 then 2; on the third timeout fail=1, retry_cnt=3, mmcm_rst=0, sys_rst_n=0, and they stay so for ≥500 cycles.
- Glitch during STABLE:
  - Stimulus: locked drops for 3 cycles after 5 qualified cycles, then returns high.
  - Response: no RUN entry; sys_rst_n rises 11 edges after locked re-rises; retry_cnt=0; no mmcm_rst pulse.
- Lock loss in RUN:
  - Stimulus: locked falls.
  - Response: sys_rst_n=0 and clk_ok=0 after 3 edges; mmcm_rst high for 4 cycles; re-lock sequence repeats normally.
- soft_rst recovery:
  - Stimulus: one-cycle soft_rst in FAIL, and separately in RUN.
  - Response: next edge gives mmcm_rst=1, fail=0, retry_cnt=0, sys_rst_n=0; normal bring-up follows.
- Asynchronous reset mid-STABLE:
  - Stimulus: reset=0 between clock edges.
  - Response: mmcm_rst=1, sys_rst_n=0, clk_ok=0, fail=0, retry_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/mmcm_lock_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmcm_lock_ctrl_if                                                |
// | Brief    : Clock wizard control/status and system reset bundle.             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mmcm_lock_ctrl_if;
    logic       locked;
    logic       soft_rst;
    logic       mmcm_rst;
    logic       sys_rst_n;
    logic       clk_ok;
    logic       fail;
    logic [3:0] retry_cnt;

    modport master (
        input  locked,
        input  soft_rst,
        output mmcm_rst,
        output sys_rst_n,
        output clk_ok,
        output fail,
        output retry_cnt
    );

    modport slave (
        output locked,
        output soft_rst,
        input  mmcm_rst,
        input  sys_rst_n,
        input  clk_ok,
        input  fail,
        input  retry_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mmcm_lock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmcm_lock_ctrl                                                   |
// | Brief    : Pulses MMCM reset, qualifies lock with timeout/retry, then       |
// |            releases the downstream system reset.                           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmcm_lock_ctrl #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 65535,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 3
) (
    input  wire logic        clk_in1,
    input  wire logic        reset,
    mmcm_lock_ctrl_if.master ctrl
);

    localparam int c_CNT_MAX_A = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > LOCK_STABLE_CYC) ? c_CNT_MAX_A : LOCK_STABLE_CYC;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PULSE_LAST   = c_CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [3:0]         c_MAX_RETRY    = 4'(MAX_RETRY);
    localparam logic [3:0]         c_RETRY_SAT    = 4'd15;

    localparam logic [2:0] c_ST_PLL_RST   = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAIL      = 3'd4;

    logic               r_locked_meta;
    logic               r_locked_s;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_retry_cnt;
    logic [3:0]         w_retry_nxt;
    logic [3:0]         w_retry_inc;
    logic               r_mmcm_rst;
    logic               r_sys_rst_n;
    logic               r_clk_ok;
    logic               r_fail;
    logic               w_mmcm_rst_nxt;
    logic               w_run_nxt;
    logic               w_fail_nxt;

    assign w_retry_inc = (r_retry_cnt == c_RETRY_SAT) ? c_RETRY_SAT : (r_retry_cnt + 4'd1);

    // State register, lock synchronizer and registered outputs.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
            r_state       <= c_ST_PLL_RST;
            r_cnt         <= '0;
            r_retry_cnt   <= 4'd0;
            r_mmcm_rst    <= 1'b1;
            r_sys_rst_n   <= 1'b0;
            r_clk_ok      <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_locked_meta <= ctrl.locked;
            r_locked_s    <= r_locked_meta;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_retry_cnt   <= w_retry_nxt;
            r_mmcm_rst    <= w_mmcm_rst_nxt;
            r_sys_rst_n   <= w_run_nxt;
            r_clk_ok      <= w_run_nxt;
            r_fail        <= w_fail_nxt;
        end
    end

    // Next-state logic; soft_rst overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_retry_nxt = r_retry_cnt;
        if (ctrl.soft_rst) begin
            w_state_nxt = c_ST_PLL_RST;
            w_retry_nxt = 4'd0;
        end else begin
            case (r_state)
                c_ST_PLL_RST: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        w_state_nxt = c_ST_WAIT_LOCK;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = c_ST_STABLE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc > c_MAX_RETRY) ? c_ST_FAIL : c_ST_PLL_RST;
                    end
                end
                c_ST_STABLE: begin
                    if (!r_locked_s) begin
                        w_state_nxt = c_ST_WAIT_LOCK;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = c_ST_RUN;
                        w_retry_nxt = 4'd0;
                    end
                end
                c_ST_RUN: begin
                    w_cnt_nxt = '0;
                    if (!r_locked_s) begin
                        w_state_nxt = c_ST_PLL_RST;
                    end
                end
                c_ST_FAIL: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = c_ST_PLL_RST;
                end
            endcase
        end
        // Held soft_rst also pins the count so the pulse is timed from its release.
        if (ctrl.soft_rst || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end
    end

    // Outputs follow the state being entered on this edge.
    always_comb begin
        w_mmcm_rst_nxt = (w_state_nxt == c_ST_PLL_RST);
        w_run_nxt      = (w_state_nxt == c_ST_RUN);
        w_fail_nxt     = (w_state_nxt == c_ST_FAIL);
    end

    assign ctrl.mmcm_rst  = r_mmcm_rst;
    assign ctrl.sys_rst_n = r_sys_rst_n;
    assign ctrl.clk_ok    = r_clk_ok;
    assign ctrl.fail      = r_fail;
    assign ctrl.retry_cnt = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_lock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mmcm_lock_ctrl                                                |
// | Brief    : Directed and randomized bench with a phase/elapsed-time model.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mmcm_lock_ctrl;

    localparam int c_PULSE   = 4;
    localparam int c_TIMEOUT = 100;
    localparam int c_STABLE  = 8;
    localparam int c_MAXR    = 2;

    logic clk_in1 = 1'b0;
    logic reset   = 1'b0;
    always #10 clk_in1 = ~clk_in1;

    mmcm_lock_ctrl_if bus ();

    bit auto_mode = 1'b0;
    bit auto_lk   = 1'b0;
    bit man_lk    = 1'b0;
    assign bus.locked = auto_mode ? auto_lk : man_lk;

    mmcm_lock_ctrl #(
        .RST_PULSE_CYC    (c_PULSE),
        .LOCK_TIMEOUT_CYC (c_TIMEOUT),
        .LOCK_STABLE_CYC  (c_STABLE),
        .MAX_RETRY        (c_MAXR)
    ) dut (
        .clk_in1 (clk_in1),
        .reset   (reset),
        .ctrl    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference: which phase we are in and how many edges it has lasted.
    typedef enum int {P_PULSE, P_WAIT, P_QUAL, P_RUN, P_FAIL} phase_t;
    phase_t m_phase   = P_PULSE;
    int     m_el      = 0;
    int     m_retries = 0;
    bit     m_s0      = 1'b0;
    bit     m_s1      = 1'b0;

    task automatic model_step();
        bit ls;
        ls   = m_s1;
        m_s1 = m_s0;
        m_s0 = bus.locked;
        if (bus.soft_rst) begin
            m_phase = P_PULSE; m_el = 0; m_retries = 0;
        end else begin
            case (m_phase)
                P_PULSE: begin
                    m_el++;
                    if (m_el == c_PULSE) begin m_phase = P_WAIT; m_el = 0; end
                end
                P_WAIT: begin
                    if (ls) begin
                        m_phase = P_QUAL; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == c_TIMEOUT) begin
                            m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                            m_phase   = (m_retries > c_MAXR) ? P_FAIL : P_PULSE;
                            m_el      = 0;
                        end
                    end
                end
                P_QUAL: begin
                    if (!ls) begin
                        m_phase = P_WAIT; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == c_STABLE) begin m_phase = P_RUN; m_el = 0; m_retries = 0; end
                    end
                end
                P_RUN: if (!ls) begin m_phase = P_PULSE; m_el = 0; end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk_in1 or negedge reset);
        if (!reset) begin
            m_phase = P_PULSE; m_el = 0; m_retries = 0; m_s0 = 1'b0; m_s1 = 1'b0;
        end else begin
            model_step();
        end
    end

    // Every-cycle compare against the model.
    initial forever begin
        logic [7:0] act;
        logic [7:0] exp;
        @(negedge clk_in1);
        act = {bus.mmcm_rst, bus.sys_rst_n, bus.clk_ok, bus.fail, bus.retry_cnt};
        exp = {m_phase == P_PULSE, m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAIL, 4'(m_retries)};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL model_cmp t=%0t: got {rst,sysn,ok,fail,retry}=%b expected %b", $time, act, exp);
        end
    end

    // Wizard stand-in for the randomized phase.
    int w_t = 0;
    int w_delay = 20;
    initial forever begin
        @(negedge clk_in1);
        if (bus.mmcm_rst) begin
            auto_lk = 1'b0; w_t = 0; w_delay = $urandom_range(1, 130);
        end else begin
            w_t++;
            if (!auto_lk && w_t >= w_delay) begin
                auto_lk = 1'b1;
            end else if (auto_lk && $urandom_range(0, 299) == 0) begin
                auto_lk = 1'b0; w_t = 0; w_delay = $urandom_range(1, 15);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit sig(input int w);
        case (w)
            0:       return bus.mmcm_rst;
            1:       return bus.sys_rst_n;
            2:       return bus.fail;
            default: return bus.clk_ok;
        endcase
    endfunction

    // Negedges until the selected output reaches val; returns bound on expiry.
    task automatic count_to(input int w, input bit val, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk_in1);
            n++;
        end while (sig(w) != val && n < bound);
    endtask

    // Called right after reset release or soft_rst drop, with locked low.
    task automatic bring_up(input string tag);
        int n;
        count_to(0, 1'b0, 50, n);
        check({tag, "_pulse_len"}, n, 4);
        repeat (19) @(negedge clk_in1);
        man_lk = 1'b1;
        count_to(1, 1'b1, 200, n);
        check({tag, "_lock_to_run"}, n, 11);
        check({tag, "_clk_ok"}, int'(bus.clk_ok), 1);
        check({tag, "_retry"}, int'(bus.retry_cnt), 0);
        check({tag, "_fail"}, int'(bus.fail), 0);
    endtask

    task automatic soft_pulse();
        @(negedge clk_in1);
        bus.soft_rst = 1'b1;
        @(negedge clk_in1);
        bus.soft_rst = 1'b0;
    endtask

    task automatic check_after_soft(input string tag);
        check({tag, "_mmcm_rst"}, int'(bus.mmcm_rst), 1);
        check({tag, "_fail"}, int'(bus.fail), 0);
        check({tag, "_retry"}, int'(bus.retry_cnt), 0);
        check({tag, "_sys_rst_n"}, int'(bus.sys_rst_n), 0);
    endtask

    initial begin
        int  n;
        int  n2;
        int  r1_at, r2_at, fail_at, pulse2_at;
        bit  saw_mmcm, saw_run, fail_broke;
        int  soft_left;

        bus.soft_rst = 1'b0;
        repeat (3) @(negedge clk_in1);
        check("reset_state", int'({bus.mmcm_rst, bus.sys_rst_n, bus.clk_ok, bus.fail, bus.retry_cnt}), 8'b1000_0000);
        reset = 1'b1;
        bring_up("bringup");

        // Lock loss while running.
        @(negedge clk_in1);
        man_lk = 1'b0;
        count_to(1, 1'b0, 20, n);
        check("loss_sysn_delay", n, 3);
        check("loss_mmcm_rst", int'(bus.mmcm_rst), 1);
        check("loss_clk_ok", int'(bus.clk_ok), 0);
        count_to(0, 1'b0, 20, n2);
        check("loss_pulse_len", n2, 4);

        // Lock glitch during qualification.
        repeat (5) @(negedge clk_in1);
        saw_mmcm = 1'b0; saw_run = 1'b0;
        man_lk = 1'b1;
        repeat (7) begin @(negedge clk_in1); saw_mmcm |= bus.mmcm_rst; saw_run |= bus.sys_rst_n; end
        man_lk = 1'b0;
        repeat (3) begin @(negedge clk_in1); saw_mmcm |= bus.mmcm_rst; saw_run |= bus.sys_rst_n; end
        man_lk = 1'b1;
        n = 0;
        do begin @(negedge clk_in1); n++; saw_mmcm |= bus.mmcm_rst; end while (!bus.sys_rst_n && n < 200);
        check("glitch_relock_to_run", n, 11);
        check("glitch_no_early_run", int'(saw_run), 0);
        check("glitch_no_pulse", int'(saw_mmcm), 0);
        check("glitch_retry", int'(bus.retry_cnt), 0);

        // soft_rst while running.
        @(negedge clk_in1);
        bus.soft_rst = 1'b1; man_lk = 1'b0;
        @(negedge clk_in1);
        bus.soft_rst = 1'b0;
        check_after_soft("soft_run");
        check("soft_run_clk_ok", int'(bus.clk_ok), 0);
        bring_up("soft_run_bringup");

        // Timeouts into failure.
        @(negedge clk_in1);
        bus.soft_rst = 1'b1; man_lk = 1'b0;
        @(negedge clk_in1);
        bus.soft_rst = 1'b0;
        r1_at = -1; r2_at = -1; fail_at = -1; pulse2_at = -1; fail_broke = 1'b0;
        for (int i = 1; i <= 830; i++) begin
            @(negedge clk_in1);
            if (r1_at < 0 && bus.retry_cnt == 4'd1) r1_at = i;
            if (r2_at < 0 && bus.retry_cnt == 4'd2) r2_at = i;
            if (pulse2_at < 0 && i > 4 && bus.mmcm_rst) pulse2_at = i;
            if (fail_at < 0 && bus.fail) fail_at = i;
            if (fail_at > 0 && !(bus.fail && bus.retry_cnt == 4'd3 && !bus.mmcm_rst && !bus.sys_rst_n))
                fail_broke = 1'b1;
        end
        check("timeout_retry1_at", r1_at, 104);
        check("timeout_pulse_period", pulse2_at, 104);
        check("timeout_retry2_at", r2_at, 208);
        check("timeout_fail_at", fail_at, 312);
        check("fail_held_500", int'(fail_broke), 0);
        check("fail_retry", int'(bus.retry_cnt), 3);

        // soft_rst out of FAIL.
        soft_pulse();
        check_after_soft("soft_fail");
        bring_up("soft_fail_bringup");

        // Asynchronous reset while qualifying lock.
        @(negedge clk_in1);
        bus.soft_rst = 1'b1; man_lk = 1'b0;
        @(negedge clk_in1);
        bus.soft_rst = 1'b0;
        count_to(0, 1'b0, 50, n);
        man_lk = 1'b1;
        repeat (5) @(negedge clk_in1);
        #3 reset = 1'b0;
        #1;
        check("async_reset_outputs", int'({bus.mmcm_rst, bus.sys_rst_n, bus.clk_ok, bus.fail, bus.retry_cnt}), 8'b1000_0000);
        man_lk = 1'b0;
        @(negedge clk_in1);
        reset = 1'b1;
        bring_up("post_reset_bringup");

        // Randomized traffic against the model.
        auto_mode = 1'b1;
        soft_left = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_in1);
            if (soft_left > 0) soft_left--;
            else if ($urandom_range(0, 399) == 0) soft_left = $urandom_range(1, 3);
            bus.soft_rst = (soft_left > 0);
            if ($urandom_range(0, 3999) == 0) begin
                #5 reset = 1'b0;
                repeat (2) @(negedge clk_in1);
                reset = 1'b1;
            end
        end
        bus.soft_rst = 1'b0;
        repeat (2) @(negedge clk_in1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
